mips_muldiv: RTL
================

# mips_muldiv

Iterative multiply/divide unit with the architectural HI/LO registers. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO alongside the combinational execute-stage ALU. The unit takes the same 32-bit operand pair the ALU receives and raises `md__busy` while an operation is in flight, so decode can stall MFHI, MFLO and any later mul/div instruction. HI/LO are read combinationally by the MFHI/MFLO path.

## Interface
- `ITER_BITS`, default 1: quotient/product bits retired per cycle. Legal values are 1, 2 and 4. Iteration count is `N = 32/ITER_BITS`.
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `md__start` in 1: request. Sampled only in IDLE.
- `md__sel` in 3: operation select. 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO. Codes 6 and 7 are no-ops.
- `md__op1` in 32: rs operand. It is the multiplicand or dividend, and the MTHI/MTLO source.
- `md__op2` in 32: rt operand. It is the multiplier or divisor.
- `md__flush` in 1: abort any in-flight operation.
- `md__busy` out 1: operation in flight. Reset 0.
- `md__done` out 1: one-cycle completion pulse. Reset 0.
- `md__hi` out 32: HI register. Reset 0.
- `md__lo` out 32: LO register. Reset 0.

## Operation
- The FSM has three states: IDLE, RUN and FIX. Reset forces IDLE, clears HI/LO, `md__busy` and `md__done`, and zeroes the iteration counter.
- IDLE with `md__start` and sel 0–3:
  - latch the operands and the operation;
  - for signed ops, convert both operands to magnitudes and record the result signs;
  - load counter = N, then go to RUN.
- IDLE with `md__start` and sel 4/5: write `md__op1` into HI (4) or LO (5) on that edge. The FSM stays in IDLE, with no busy and no done.
- RUN:
  - multiply uses shift-add, consuming multiplier LSBs first and `ITER_BITS` per edge;
  - divide uses restoring division, producing `ITER_BITS` quotient bits per edge;
  - when the counter reaches 0, go to FIX.
- FIX:
  - apply the sign correction;
  - write HI/LO, pulse `md__done`, go to IDLE.
- MULT: the 64-bit product is negated when the operand signs differ. HI gets `[63:32]` and LO gets `[31:0]`.
- MULTU: unsigned 64-bit product.
- DIV:
  - LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend;
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (DIV or DIVU): HI = `md__op1`, LO = 0xFFFFFFFF. No exception is raised.
- `md__start` while not in IDLE is ignored and not queued. Decode must hold the instruction until `md__busy` is low.
- `md__flush` in RUN or FIX:
  - return to IDLE on that edge;
  - HI/LO are unchanged and no done pulse is issued.
- `md__flush` together with `md__start` in IDLE: flush wins and start is ignored.
- Flush in IDLE has no other effect.
- `rst` mid-operation: behaves as reset, which clears HI/LO.

## Timing
- Start is accepted at edge E0. `md__busy` is 1 from E0 until E(N+1).
- RUN iterations occur on edges E1..EN. FIX occurs at E(N+1).
- After E(N+1):
  - `md__busy` is 0 and `md__done` is 1 for exactly one cycle;
  - the new HI/LO are visible in that same cycle.
- Total latency is N+1 edges: 33 with `ITER_BITS`=1, 17 with 2, 9 with 4.
- A new start is accepted in the cycle where `md__done` is 1, so back-to-back operations are allowed.
- MTHI/MTLO take effect after 1 edge. The value is visible in the next cycle.
- All outputs come straight from registers, with no combinational input-to-output path.

## Configuration
- `MD_EARLY_OUT_EN` defined:
  - MULT/MULTU whose multiplier magnitude has bits `[31:16]` all zero finish RUN after N/2 iterations;
  - the product is realigned in FIX;
  - latency is N/2+1 edges.
- Divide and all other cases are unchanged.
- `MD_EARLY_OUT_EN` undefined: every mul/div has the fixed latency N+1.

## Test plan
- MULT 0xFFFFFFFF × 0x00000007 (`ITER_BITS`=1) -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF9. `md__busy` is high for 33 cycles and `md__done` pulses once, with busy already low.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001. A second MULTU started on the done cycle is accepted.
- DIV 0xFFFFFFF9 ÷ 0x00000002 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 0x00000007 ÷ 0 -> HI = 0x00000007, LO = 0xFFFFFFFF.
- DIV 0x80000000 ÷ 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- Flush case:
  - preload HI = 0x1234 via MTHI (visible the next cycle);
  - start MULT 3×5 and assert `md__flush` on the 10th busy cycle -> busy drops the next cycle, no done, HI remains 0x1234;
  - a start asserted during busy is ignored.
- `MD_EARLY_OUT_EN` defined: MULTU 5×3 -> LO = 15, HI = 0, done after 17 edges.
- `MD_EARLY_OUT_EN` undefined: the same MULTU completes after 33 edges.

Source files
------------

// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// Multiply is LSB-first shift-add, divide is restoring; ITER_BITS bits retire per edge.
// Optional feature macro: MD_EARLY_OUT_EN (multipliers whose magnitude fits in 16 bits
// finish after half the iterations).

module mips_muldiv #(
  parameter int unsigned ITER_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        md__start,
  input  logic [2:0]  md__sel,
  input  logic [31:0] md__op1,
  input  logic [31:0] md__op2,
  input  logic        md__flush,
  output logic        md__busy,
  output logic        md__done,
  output logic [31:0] md__hi,
  output logic [31:0] md__lo
);

  localparam int unsigned N    = 32 / ITER_BITS;
  localparam int unsigned CntW = 6;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  // Mul: {partial high, multiplier/low}. Div: {remainder, dividend/quotient}.
  logic [63:0]     r_p, w_p_d, w_step;
  logic [31:0]     r_mcand, w_mcand_d;  // multiplicand or divisor magnitude
  logic            r_is_div, w_is_div_d;
  logic            r_neg_q, w_neg_q_d;  // negate product / quotient
  logic            r_neg_r, w_neg_r_d;  // negate remainder
  logic            r_div0, w_div0_d;
  logic            r_early, w_early_d;
  logic [31:0]     r_op1, w_op1_d;
  logic [31:0]     r_hi, w_hi_d, r_lo, w_lo_d;
  logic            r_busy, w_busy_d, r_done, w_done_d;

  logic            w_signed, w_s1, w_s2, w_early_ok;
  logic [31:0]     w_mag1, w_mag2;
  logic [32:0]     w_rem, w_sum;
  logic [63:0]     w_prod;
  logic [31:0]     w_quo, w_rem_fix, w_fix_hi, w_fix_lo;

  // Operand magnitudes and result signs for a newly accepted mul/div.
  always_comb begin
    w_signed = ~md__sel[0];
    w_s1     = w_signed & md__op1[31];
    w_s2     = w_signed & md__op2[31];
    w_mag1   = w_s1 ? (~md__op1 + 32'd1) : md__op1;
    w_mag2   = w_s2 ? (~md__op2 + 32'd1) : md__op2;
  end

`ifdef MD_EARLY_OUT_EN
  assign w_early_ok = ~md__sel[1] & (w_mag2[31:16] == 16'd0);
`else
  assign w_early_ok = 1'b0;
`endif

  // One RUN edge worth of shift-add or restoring-divide steps.
  always_comb begin
    w_step = r_p;
    w_rem  = '0;
    w_sum  = '0;
    for (int k = 0; k < ITER_BITS; k++) begin
      if (r_is_div) begin
        w_rem  = {w_step[63:32], w_step[31]};
        w_step = {w_step[62:0], 1'b0};
        if (w_rem >= {1'b0, r_mcand}) begin
          w_rem     = w_rem - {1'b0, r_mcand};
          w_step[0] = 1'b1;
        end
        // After a successful subtract the remainder is below the divisor, so 32 bits hold it.
        w_step[63:32] = w_rem[31:0];
      end else begin
        w_sum  = {1'b0, w_step[63:32]} + (w_step[0] ? {1'b0, r_mcand} : 33'd0);
        w_step = {w_sum, w_step[31:1]};
      end
    end
  end

  // Sign correction and realignment applied in FIX.
  always_comb begin
    // Early-out leaves the product 16 bits high because only 16 shifts happened.
    w_prod = r_early ? {16'd0, r_p[63:16]} : r_p;
    if (r_neg_q) begin
      w_prod = ~w_prod + 64'd1;
    end
    w_quo     = r_neg_q ? (~r_p[31:0] + 32'd1) : r_p[31:0];
    w_rem_fix = r_neg_r ? (~r_p[63:32] + 32'd1) : r_p[63:32];
    if (!r_is_div) begin
      w_fix_hi = w_prod[63:32];
      w_fix_lo = w_prod[31:0];
    end else if (r_div0) begin
      w_fix_hi = r_op1;
      w_fix_lo = 32'hFFFF_FFFF;
    end else begin
      w_fix_hi = w_rem_fix;
      w_fix_lo = w_quo;
    end
  end

  // Next-state logic for the FSM, datapath and HI/LO.
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_p_d      = r_p;
    w_mcand_d  = r_mcand;
    w_is_div_d = r_is_div;
    w_neg_q_d  = r_neg_q;
    w_neg_r_d  = r_neg_r;
    w_div0_d   = r_div0;
    w_early_d  = r_early;
    w_op1_d    = r_op1;
    w_hi_d     = r_hi;
    w_lo_d     = r_lo;
    w_done_d   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (md__start && !md__flush) begin
          case (md__sel)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              w_is_div_d = md__sel[1];
              w_neg_q_d  = w_s1 ^ w_s2;
              w_neg_r_d  = w_s1;
              w_div0_d   = md__sel[1] & (md__op2 == 32'd0);
              w_early_d  = w_early_ok;
              w_op1_d    = md__op1;
              w_p_d      = md__sel[1] ? {32'd0, w_mag1} : {32'd0, w_mag2};
              w_mcand_d  = md__sel[1] ? w_mag2 : w_mag1;
              w_cnt_d    = w_early_ok ? CntW'(N / 2) : CntW'(N);
              w_state_d  = StRun;
            end
            3'd4:    w_hi_d = md__op1;
            3'd5:    w_lo_d = md__op1;
            default: ;
          endcase
        end
      end
      StRun: begin
        if (md__flush) begin
          w_state_d = StIdle;
        end else begin
          w_p_d   = w_step;
          w_cnt_d = r_cnt - CntW'(1);
          if (r_cnt == CntW'(1)) begin
            w_state_d = StFix;
          end
        end
      end
      StFix: begin
        w_state_d = StIdle;
        if (!md__flush) begin
          w_hi_d   = w_fix_hi;
          w_lo_d   = w_fix_lo;
          w_done_d = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
    w_busy_d = (w_state_d != StIdle);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_p      <= '0;
      r_mcand  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_early  <= 1'b0;
      r_op1    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_p      <= w_p_d;
      r_mcand  <= w_mcand_d;
      r_is_div <= w_is_div_d;
      r_neg_q  <= w_neg_q_d;
      r_neg_r  <= w_neg_r_d;
      r_div0   <= w_div0_d;
      r_early  <= w_early_d;
      r_op1    <= w_op1_d;
      r_hi     <= w_hi_d;
      r_lo     <= w_lo_d;
      r_busy   <= w_busy_d;
      r_done   <= w_done_d;
    end
  end

  assign md__busy = r_busy;
  assign md__done = r_done;
  assign md__hi   = r_hi;
  assign md__lo   = r_lo;

endmodule
